// File: rtl/bootram_pkg.sv
// bootram_pkg: shared types and constants for the boot RAM controller.
//   state_t        - controller FSM states
//   BOOTRAM_ADDR_W - default word-address width of each 2Kx8 byte-lane RAM
//   BOOTRAM_LANES  - number of byte lanes (fixed at 4)
//   lane_onehot()  - byte-lane select from the two low pointer bits
package bootram_pkg;

   localparam int BOOTRAM_ADDR_W = 11;
   localparam int BOOTRAM_LANES  = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_DATA  = 3'd2,
      WR_ISSUE = 3'd3,
      LD_ISSUE = 3'd4,
      DONE     = 3'd5
   } state_t;

   function automatic logic [BOOTRAM_LANES-1:0] lane_onehot(input logic [1:0] sel);
      logic [BOOTRAM_LANES-1:0] oh;
      oh      = {BOOTRAM_LANES{1'b0}};
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/bootram_rr_arb.sv
// bootram_rr_arb: two-way round-robin arbiter between the CPU port and the
// byte loader.
//   clk, resetn      - clock, asynchronous active-low reset
//   en               - arbitration allowed this cycle (controller idle)
//   req_cpu, req_ld  - pending requests
//   gnt_cpu, gnt_ld  - one-hot grant, valid only while en is high
// After reset the CPU counts as last served, so the loader wins the first tie.
module bootram_rr_arb
(
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic req_cpu,
   input  logic req_ld,
   output logic gnt_cpu,
   output logic gnt_ld
);

   logic last_cpu_r;

   // Grant decode: a lone requester wins, a tie goes to the side not served last.
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_ld  = 1'b0;
      if (en) begin
         if (req_cpu && req_ld) begin
            if (last_cpu_r) begin
               gnt_ld = 1'b1;
            end else begin
               gnt_cpu = 1'b1;
            end
         end else begin
            gnt_cpu = req_cpu;
            gnt_ld  = req_ld;
         end
      end else begin
         gnt_cpu = 1'b0;
         gnt_ld  = 1'b0;
      end
   end

   // Last-served tracker.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_cpu_r <= 1'b1;
      end else if (gnt_cpu) begin
         last_cpu_r <= 1'b1;
      end else if (gnt_ld) begin
         last_cpu_r <= 1'b0;
      end
   end

endmodule

// File: rtl/bootram_ctrl.sv
// bootram_ctrl: shares four 2Kx8 byte-lane block RAMs between a 32-bit CPU
// port (valid/ready) and a byte-serial boot loader.
//   clk, resetn                         - clock, asynchronous active-low reset
//   mem_valid/ready/addr/wdata/wstrb/rdata - CPU port, wstrb==0 is a read
//   ld_start, ld_valid, ld_data         - loader pointer clear and byte stream
//   ld_ready                            - one-cycle byte-accepted pulse
//   ld_ovf                              - sticky loader pointer wrap flag
//   ram_ad/din/ce/wre/oce/reset         - registered RAM controls, shared address
//   ram_dout                            - concatenated lane outputs (bypass mode)
module bootram_ctrl
   import bootram_pkg::*;
#(
   parameter int ADDR_W = BOOTRAM_ADDR_W,
   parameter int LANES  = BOOTRAM_LANES
)
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [ADDR_W+1:0]    mem_addr,
   input  logic [8*LANES-1:0]   mem_wdata,
   input  logic [LANES-1:0]     mem_wstrb,
   output logic [8*LANES-1:0]   mem_rdata,
   input  logic                 ld_start,
   input  logic                 ld_valid,
   input  logic [7:0]           ld_data,
   output logic                 ld_ready,
   output logic                 ld_ovf,
   output logic [ADDR_W-1:0]    ram_ad,
   output logic [8*LANES-1:0]   ram_din,
   output logic [LANES-1:0]     ram_ce,
   output logic                 ram_wre,
   output logic                 ram_oce,
   output logic                 ram_reset,
   input  logic [8*LANES-1:0]   ram_dout
);

   localparam int PTR_W = ADDR_W + 2;
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_MAX  = {PTR_W{1'b1}};

   state_t           state_r;
   logic [PTR_W-1:0] ptr_r;
   logic             gnt_cpu_s;
   logic             gnt_ld_s;
   logic             unused_addr_s;

   // Byte offset within a word is irrelevant: the CPU port is word-wide.
   assign unused_addr_s = ^mem_addr[1:0];

   assign ram_oce   = 1'b1;
   assign ram_reset = 1'b0;

   bootram_rr_arb u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .en      (state_r == IDLE),
      .req_cpu (mem_valid),
      .req_ld  (ld_valid),
      .gnt_cpu (gnt_cpu_s),
      .gnt_ld  (gnt_ld_s)
   );

   // Controller FSM; every RAM control and handshake output is a register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         mem_ready <= 1'b0;
         ld_ready  <= 1'b0;
         mem_rdata <= {(8*LANES){1'b0}};
         ram_ce    <= {LANES{1'b0}};
         ram_wre   <= 1'b0;
         ram_ad    <= {ADDR_W{1'b0}};
         ram_din   <= {(8*LANES){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (gnt_ld_s) begin
                  // ld_ready rises with the grant so the source advances its
                  // byte before the FSM is back in IDLE sampling ld_valid.
                  ram_ce   <= lane_onehot(ptr_r[1:0]);
                  ram_wre  <= 1'b1;
                  ram_ad   <= ptr_r[ADDR_W+1:2];
                  ram_din  <= {LANES{ld_data}};
                  ld_ready <= 1'b1;
                  state_r  <= LD_ISSUE;
               end else if (gnt_cpu_s) begin
                  ram_ad <= mem_addr[ADDR_W+1:2];
                  if (mem_wstrb == {LANES{1'b0}}) begin
                     ram_ce  <= {LANES{1'b1}};
                     ram_wre <= 1'b0;
                     state_r <= RD_ISSUE;
                  end else begin
                     ram_ce  <= mem_wstrb;
                     ram_wre <= 1'b1;
                     ram_din <= mem_wdata;
                     state_r <= WR_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               ram_ce  <= {LANES{1'b0}};
               ram_wre <= 1'b0;
               state_r <= RD_DATA;
            end
            RD_DATA: begin
               mem_rdata <= ram_dout;
               mem_ready <= 1'b1;
               state_r   <= DONE;
            end
            WR_ISSUE: begin
               ram_ce    <= {LANES{1'b0}};
               ram_wre   <= 1'b0;
               mem_ready <= 1'b1;
               state_r   <= DONE;
            end
            LD_ISSUE: begin
               ram_ce   <= {LANES{1'b0}};
               ram_wre  <= 1'b0;
               ld_ready <= 1'b0;
               state_r  <= IDLE;
            end
            DONE: begin
               // Extra cycle lets the CPU drop a held mem_valid before IDLE.
               mem_ready <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               ram_ce    <= {LANES{1'b0}};
               ram_wre   <= 1'b0;
               mem_ready <= 1'b0;
               ld_ready  <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // Loader pointer and wrap flag; ld_start beats a same-cycle increment.
   // The address of an accepted byte is already latched in ram_ad, so a clear
   // here never redirects the write that is in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_r  <= PTR_ZERO;
         ld_ovf <= 1'b0;
      end else if (ld_start) begin
         ptr_r  <= PTR_ZERO;
         ld_ovf <= 1'b0;
      end else if (gnt_ld_s) begin
         ptr_r <= ptr_r + PTR_ONE;
         if (ptr_r == PTR_MAX) begin
            ld_ovf <= 1'b1;
         end
      end
   end

endmodule
